mipi_csi2_capture_ctrl: RTL

Capture sequencer between the CSI-2 deserializer and the image pipeline. It enables the deserializer and aligns capture to a clean frame start. It gates the frame/line/data stream into either single-shot captures of N frames or continuous capture. It measures frame geometry and flags timeouts and line-length inconsistencies for host status registers.

---
 rtl/mipi_csi2_capture_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mipi_csi2_capture_ctrl.sv
// rtl/mipi_csi2_capture_ctrl.sv - CSI-2 capture sequencer: frame-aligned gating, geometry and timeout status
module mipi_csi2_capture_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT_W  = 24
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  cmd_start,
    input  logic                  cmd_stop,
    input  logic                  mode_cont,
    input  logic [7:0]            num_frames,
    input  logic [TIMEOUT_W-1:0]  timeout_cycles,
    input  logic                  fvi,
    input  logic                  lvi,
    input  logic [DATA_WIDTH-1:0] dati,
    output logic                  des_enable,
    output logic                  fvo,
    output logic                  lvo,
    output logic [DATA_WIDTH-1:0] dato,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic [CNT_W-1:0]      lines_last,
    output logic [CNT_W-1:0]      pixels_last,
    output logic                  err_timeout,
    output logic                  err_line_len
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_FS,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    localparam logic [CNT_W-1:0]     CNT_MAX = {CNT_W{1'b1}};
    localparam logic [TIMEOUT_W-1:0] TO_MAX  = {TIMEOUT_W{1'b1}};

    state_t                 state, state_nxt;
    logic                   fvi_q, lvi_q;
    logic                   fs, fe, ls, le, stream_edge;
    logic                   capturing, count_fe, last_frame, to_hit, gate;
    logic                   mode_q;
    logic [CNT_W-1:0]       nf_q;
    logic [TIMEOUT_W-1:0]   to_q, to_cnt;
    logic [CNT_W-1:0]       line_cnt, pix_cnt, ref_len;
    logic                   ref_valid;

    assign fs          = fvi & ~fvi_q;
    assign fe          = ~fvi & fvi_q;
    assign ls          = lvi & ~lvi_q & fvi;
    // Line ends are only meaningful inside a frame; stray lvi outside fvi is ignored.
    assign le          = ~lvi & lvi_q & fvi_q;
    assign stream_edge = (fvi ^ fvi_q) | (lvi ^ lvi_q);

    assign capturing  = (state == S_CAPTURE) | (state == S_DRAIN);
    assign count_fe   = capturing & fe;
    assign last_frame = ~mode_q & ((frame_cnt + CNT_W'(1)) == nf_q);
    assign to_hit     = (to_q != '0) & (state != S_IDLE) & ~stream_edge
                        & (to_cnt == to_q - TIMEOUT_W'(1));
    assign busy       = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (cmd_start) state_nxt = S_ARM;
            S_ARM: begin
                if (cmd_stop || to_hit) state_nxt = S_IDLE;
                else if (!fvi)          state_nxt = S_WAIT_FS;
            end
            S_WAIT_FS: begin
                if (cmd_stop)    state_nxt = S_IDLE;
                else if (fs)     state_nxt = S_CAPTURE;
                else if (to_hit) state_nxt = S_IDLE;
            end
            S_CAPTURE: begin
                // A stop coinciding with FE ends cleanly here rather than draining.
                if (fe) begin
                    if (last_frame || cmd_stop) state_nxt = S_IDLE;
                end else if (cmd_stop) begin
                    state_nxt = fvi_q ? S_DRAIN : S_IDLE;
                end else if (to_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN:   if (fe || to_hit) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Never forward anything on the cycle we leave for IDLE (stop, timeout, last FE).
    assign gate = (capturing | ((state == S_WAIT_FS) & fs)) & (state_nxt != S_IDLE);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state      <= S_IDLE;
            fvi_q      <= 1'b0;
            lvi_q      <= 1'b0;
            done       <= 1'b0;
            des_enable <= 1'b0;
            fvo        <= 1'b0;
            lvo        <= 1'b0;
            dato       <= '0;
        end else begin
            state      <= state_nxt;
            fvi_q      <= fvi;
            lvi_q      <= lvi;
            done       <= (state != S_IDLE) & (state_nxt == S_IDLE);
            des_enable <= (state_nxt != S_IDLE);
            fvo        <= gate & fvi;
            lvo        <= gate & fvi & lvi;
            if (gate && lvi) dato <= dati;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            mode_q       <= 1'b0;
            nf_q         <= '0;
            to_q         <= '0;
            frame_cnt    <= '0;
            lines_last   <= '0;
            pixels_last  <= '0;
            err_timeout  <= 1'b0;
            err_line_len <= 1'b0;
        end else if ((state == S_IDLE) && cmd_start) begin
            mode_q       <= mode_cont;
            nf_q         <= (num_frames == 8'd0) ? CNT_W'(1) : CNT_W'(num_frames);
            to_q         <= timeout_cycles;
            frame_cnt    <= '0;
            err_timeout  <= 1'b0;
            err_line_len <= 1'b0;
        end else begin
            if (count_fe) begin
                if (frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + CNT_W'(1);
                lines_last  <= line_cnt;
                // A single-line frame can end its line and frame together.
                pixels_last <= ref_valid ? ref_len : pix_cnt;
            end
            if (to_hit) err_timeout <= 1'b1;
            if (capturing && le && ref_valid && (pix_cnt != ref_len)) err_line_len <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            line_cnt  <= '0;
            pix_cnt   <= '0;
            ref_len   <= '0;
            ref_valid <= 1'b0;
        end else begin
            if (fs)                               line_cnt <= ls ? CNT_W'(1) : '0;
            else if (ls && (line_cnt != CNT_MAX)) line_cnt <= line_cnt + CNT_W'(1);

            // The LS cycle already carries the first pixel.
            if (ls)                                         pix_cnt <= CNT_W'(1);
            else if (lvi && fvi && (pix_cnt != CNT_MAX))    pix_cnt <= pix_cnt + CNT_W'(1);

            if (fs) begin
                ref_valid <= 1'b0;
            end else if (le && !ref_valid) begin
                ref_len   <= pix_cnt;
                ref_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)                                  to_cnt <= '0;
        else if ((state_nxt != state) || stream_edge) to_cnt <= '0;
        else if (to_cnt != TO_MAX)                    to_cnt <= to_cnt + TIMEOUT_W'(1);
    end

endmodule
